shift_add_mult_ctrl: RTL and testbench
======================================

# shift_add_mult_ctrl

Sequential unsigned multiplier controller that sequences the single-bit left-shift datapath over W iterations to form a 2W-bit product by shift-and-add. It sits beside the ALU as the multi-cycle multiply unit: the core hands it two operands with a one-cycle start strobe and receives the product with a one-cycle done strobe. One operation is in flight at a time; fixed latency, no early termination.

## Interface
- W, 16, operand width in bits (W >= 2); product width is 2W
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only when ready=1
- multiplicand  in  W  unsigned operand A, sampled with accepted start
- multiplier  in  W  unsigned operand B, sampled with accepted start
- ready  out  1  high in IDLE only
- busy  out  1  high in RUN only
- done  out  1  one-cycle pulse, product valid from this cycle on
- product  out  2W  result register, holds last completed result

## Operation
- Reset is synchronous and active-low: on a clk edge with rst_n=0, state=IDLE, ready=1, busy=0, done=0, product=0, all internal registers (mcand 2W, mplier W, acc 2W, cnt) = 0.
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1: mcand <= {W'b0, multiplicand}, mplier <= multiplier, acc <= 0, cnt <= 0, go to RUN. start=0: stay.
- RUN: busy=1. Each edge: if mplier[0] then acc <= acc + mcand (2W-bit add, carry-out discarded; cannot overflow for valid operands); mcand <= mcand shifted left one bit, zero in LSB; mplier <= mplier >> 1; cnt <= cnt + 1.
- When cnt == W-1 on an edge: the final iteration completes, product <= final acc value (including that edge's addend), go to DONE.
- DONE: done=1 for exactly one cycle, ready=0, busy=0; next edge go to IDLE unconditionally.
- start is ignored outside IDLE (no queuing); operand inputs are don't-care outside the accepting edge.
- product changes only on the RUN->DONE edge and on reset; stable through IDLE and RUN of the next operation.
- cnt width is $clog2(W)+1.

## Timing
- Start accepted on edge E0 -> done=1 in the cycle after edge E0+W, i.e. W clock cycles after acceptance; ready returns the cycle after that.
- Throughput: one operation per W+2 cycles (IDLE accept, W RUN edges, DONE).
- Held-high start: accepted in IDLE, ignored through RUN/DONE, re-accepted on the first IDLE edge.
- rst_n=0 mid-RUN or in DONE: aborts at that edge, no done pulse, product=0.
- rst_n=0 and start=1 on the same edge: reset wins.

## Structure
- Shared package: state encoding typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the CNT_W localparam function.
- Sub-module: one instance of shift_left_1 with W=2W, driven by mcand, output feeding the mcand next-state mux. Multiplier right-shift and adder stay inline.

## Test plan
- W=16, A=3, B=5, start 1 cycle -> done after 16 cycles, product=32'h0000000F, ready returns next cycle.
- A=16'hFFFF, B=16'hFFFF -> product=32'hFFFE0001; A=16'h8000, B=16'h0002 -> 32'h00010000.
- A=0, B=16'h1234 and A=16'h1234, B=0 -> product=0, done still at exactly 16 cycles.
- Start pulses with new operands during RUN and DONE -> ignored, first result unchanged, no extra done.
- rst_n=0 at RUN cycle 7 -> next cycle IDLE, ready=1, product=0, no done pulse; new start afterwards completes correctly.
- start held high for 40 cycles, A=7, B=9 -> done pulses every 18 cycles, product=63 each time.

Source files
------------

// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared types for the shift-and-add multiplier.
// State encoding and counter width helper.
package shift_add_mult_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_shl.sv
// Single-bit left shift, zero fill in LSB.
// Drives the multiplicand next-state path.
module shift_left_1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  assign q = {d[W-2:0], 1'b0};

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Multi-cycle unsigned shift-and-add multiplier.
// Fixed W-cycle latency, one op in flight.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CNT_W = cnt_w(W);

  state_t state, state_nxt;

  logic [2*W-1:0] mcand;
  logic [2*W-1:0] mcand_shl;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_sum;
  logic [W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic           last;

  shift_left_1 #(
    .W(2*W)
  ) u_shl (
    .d(mcand),
    .q(mcand_shl)
  );

  assign acc_sum = mplier[0] ? acc + mcand : acc;
  assign last    = (cnt == CNT_W'(W-1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand load, iteration datapath and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        mcand  <= {{W{1'b0}}, multiplicand};
        mplier <= multiplier;
        acc    <= '0;
        cnt    <= '0;
      end
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand_shl;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) product <= acc_sum;
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Testbench for shift_add_mult_ctrl.
// Random and directed ops vs an arithmetic model.
module tb_shift_add_mult_ctrl;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_err = 0;
  int n_chk = 0;
  int n_done = 0;
  logic [2*W-1:0] exp_prod;

  shift_add_mult_ctrl #(.W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .ready(ready),
    .busy(busy),
    .done(done),
    .product(product)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) n_done <= n_done + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[2*W-1:0];
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    chk("ready_wait", ready, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit noise);
    int k;
    int d0;
    wait_ready();
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start = 1'b0;
    d0 = n_done;
    k = 0;
    while (!done && k < W + 5) begin
      if (k > 0 && k < W) begin
        chk("busy_run", {busy, ready}, 2'b10);
        chk("prod_hold", product, exp_prod);
      end
      if (noise) begin
        start        = 1'b1;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
      end
      tick();
      k++;
    end
    exp_prod = model(a, b);
    chk("latency", k, W);
    chk("product", product, exp_prod);
    chk("done_flags", {busy, ready}, 2'b00);
    tick();
    start = 1'b0;
    chk("ready_back", {ready, busy, done}, 3'b100);
    chk("prod_keep", product, exp_prod);
    chk("one_done", n_done - d0, 1);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int last_k;
    int k;
    int nd;
    rst_n = 1'b0;
    start = 1'b1;
    multiplicand = '0;
    multiplier   = '0;
    exp_prod     = '0;
    tick();
    tick();
    chk("rst_state", {ready, busy, done}, 3'b100);
    chk("rst_prod", product, 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_stay", {ready, busy}, 2'b10);

    run_op(16'd3, 16'd5, 0);
    chk("p_3x5", product, 32'h0000000F);
    run_op(16'hFFFF, 16'hFFFF, 0);
    chk("p_ffff", product, 32'hFFFE0001);
    run_op(16'h8000, 16'h0002, 0);
    chk("p_8000x2", product, 32'h00010000);
    run_op(16'h0000, 16'h1234, 0);
    run_op(16'h1234, 16'h0000, 0);

    for (int i = 0; i < 8; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      run_op(a, b, 0);
    end

    run_op(16'h00AB, 16'h0CD0, 1);

    wait_ready();
    multiplicand = 16'h1111;
    multiplier   = 16'h0003;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_busy", busy, 1);
    nd = n_done;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_state", {ready, busy, done}, 3'b100);
    chk("abort_prod", product, 0);
    exp_prod = '0;
    for (int i = 0; i < W + 3; i++) tick();
    chk("abort_nodone", n_done - nd, 0);
    run_op(16'h0102, 16'h0304, 0);

    wait_ready();
    multiplicand = 16'd7;
    multiplier   = 16'd9;
    start  = 1'b1;
    nd     = 0;
    last_k = -1;
    for (k = 0; k < 40; k++) begin
      tick();
      if (done) begin
        chk("held_prod", product, 63);
        if (last_k >= 0) chk("held_period", k - last_k, W + 2);
        last_k = k;
        nd++;
      end
    end
    start = 1'b0;
    chk("held_count", nd, 2);
    k = 0;
    while (!done && k < 3 * W) begin
      tick();
      k++;
    end
    chk("held_drain", product, 63);
    tick();
    chk("final_idle", ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
